// File: rtl/access_lock_fsm.sv
// ---------------------------------------------------------------------------
// access_lock_fsm
//
// Keypad door lock. The user enters a code one digit at a time. Each digit
// is presented on access_code and qualified by a one-cycle strobe on
// validate_code. The FSM compares the digits against the stored CODE.
//
// - A correct complete code opens the door for OPEN_CYCLES cycles.
// - A wrong complete code pulses entry_error and bumps the failure count.
// - MAX_TRIES consecutive failures lock the keypad for LOCKOUT_CYCLES
//   cycles.
// - A partially entered code is abandoned when the user goes quiet for
//   ENTRY_TIMEOUT cycles. This does not count as a failure.
//
// Ports
//   clk              : single clock, all state changes on the rising edge
//   rst              : asynchronous active-high reset
//   validate_code    : digit strobe, access_code is sampled when high
//   access_code      : current digit, CODE_W bits
//   open_access_door : door release, high only while in OPEN
//   state_out        : state register (IDLE=00 ENTRY=01 OPEN=10 LOCKOUT=11)
//   fail_count       : consecutive failed codes, saturates at MAX_TRIES
//   entry_error      : one-cycle pulse after a wrong complete code
//
// Every output is driven straight from a register. No input reaches an
// output without passing through a flop.
// ---------------------------------------------------------------------------
module access_lock_fsm #(
  parameter int CODE_W         = 4,
  parameter int NUM_DIGITS     = 2,
  parameter logic [NUM_DIGITS*CODE_W-1:0] CODE = 8'h93,
  parameter int MAX_TRIES      = 3,
  parameter int OPEN_CYCLES    = 8,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int ENTRY_TIMEOUT  = 10,
  localparam int FAIL_W        = $clog2(MAX_TRIES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validate_code,
  input  logic [CODE_W-1:0] access_code,
  output logic              open_access_door,
  output logic [1:0]        state_out,
  output logic [FAIL_W-1:0] fail_count,
  output logic              entry_error
);

  // One shared timer serves the entry timeout, the open period and the
  // lockout period, because only one of them is ever running at a time.
  // The timer is sized by the largest of the three cycle parameters, plus
  // one bit of headroom, so the terminal count cannot overflow.
  localparam int TIMER_MAX_A = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TIMER_MAX   = (TIMER_MAX_A > ENTRY_TIMEOUT) ? TIMER_MAX_A : ENTRY_TIMEOUT;
  localparam int TIMER_W     = $clog2(TIMER_MAX) + 1;
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TIMER_W-1:0] OPEN_LAST    = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCKOUT_LAST = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ENTRY_LAST   = TIMER_W'(ENTRY_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   FINAL_IDX    = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FAIL_W-1:0]  FAIL_LIMIT   = FAIL_W'(MAX_TRIES);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ENTRY   = 2'b01,
    OPEN    = 2'b10,
    LOCKOUT = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    digitIdx_q, digitIdx_d;
  logic                mismatch_q, mismatch_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [FAIL_W-1:0]   failCount_q, failCount_d;
  logic                entryError_q, entryError_d;

  logic [CODE_W-1:0]   expectedDigit;
  logic                mismatchNow;
  logic                isFinalDigit;
  logic [FAIL_W-1:0]   failInc;

  // Select the stored digit the user should be typing right now. The first
  // digit entered lives in the most significant field of CODE.
  always_comb begin
    expectedDigit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digitIdx_q == IDX_W'(i)) begin
        expectedDigit = CODE[(NUM_DIGITS-1-i)*CODE_W +: CODE_W];
      end
    end
  end

  // The verdict for the last digit must include that digit's own compare
  // result. The sticky flag only holds the earlier digits, so fold the
  // current compare in before deciding.
  always_comb begin
    mismatchNow  = mismatch_q | (access_code != expectedDigit);
    isFinalDigit = (digitIdx_q == FINAL_IDX);
    failInc      = (failCount_q == FAIL_LIMIT) ? failCount_q
                                               : failCount_q + FAIL_W'(1);
  end

  // State and datapath registers. Reset is asynchronous, so the door
  // closes immediately even while the clock is running in OPEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      digitIdx_q   <= '0;
      mismatch_q   <= 1'b0;
      timer_q      <= '0;
      failCount_q  <= '0;
      entryError_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digitIdx_q   <= digitIdx_d;
      mismatch_q   <= mismatch_d;
      timer_q      <= timer_d;
      failCount_q  <= failCount_d;
      entryError_q <= entryError_d;
    end
  end

  // Next-state and datapath logic.
  //
  // In IDLE and ENTRY, every strobe cycle consumes one digit. A strobe held
  // high for several cycles therefore enters one digit per cycle.
  //
  // In ENTRY, the timer counts consecutive idle cycles since the last
  // digit. In OPEN and LOCKOUT, it counts the dwell time and the keypad is
  // ignored.
  always_comb begin
    state_d      = state_q;
    digitIdx_d   = digitIdx_q;
    mismatch_d   = mismatch_q;
    timer_d      = timer_q;
    failCount_d  = failCount_q;
    entryError_d = 1'b0;

    case (state_q)
      IDLE, ENTRY: begin
        if (validate_code) begin
          timer_d = '0;
          if (isFinalDigit) begin
            // The entry is over whatever the verdict is, so the digit
            // tracking starts fresh for the next attempt.
            digitIdx_d = '0;
            mismatch_d = 1'b0;
            if (!mismatchNow) begin
              state_d     = OPEN;
              failCount_d = '0;
            end else begin
              entryError_d = 1'b1;
              failCount_d  = failInc;
              state_d      = (failInc == FAIL_LIMIT) ? LOCKOUT : IDLE;
            end
          end else begin
            digitIdx_d = digitIdx_q + IDX_W'(1);
            mismatch_d = mismatchNow;
            state_d    = ENTRY;
          end
        end else if (state_q == ENTRY) begin
          // Abandoning a half-typed code is not a failed attempt, so the
          // failure count and entry_error are left untouched here.
          if (timer_q == ENTRY_LAST) begin
            state_d    = IDLE;
            digitIdx_d = '0;
            mismatch_d = 1'b0;
            timer_d    = '0;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end

      OPEN: begin
        if (timer_q == OPEN_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      LOCKOUT: begin
        // Serving the full lockout wipes the failure history.
        if (timer_q == LOCKOUT_LAST) begin
          state_d     = IDLE;
          timer_d     = '0;
          failCount_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      default: begin
        state_d    = IDLE;
        digitIdx_d = '0;
        mismatch_d = 1'b0;
        timer_d    = '0;
      end
    endcase
  end

  // Moore outputs, decoded from registers only.
  always_comb begin
    state_out        = state_q;
    open_access_door = (state_q == OPEN);
    fail_count       = failCount_q;
    entry_error      = entryError_q;
  end

endmodule

// File: doc/access_lock_fsm.md
ACCESS_LOCK_FSM -- requirements
Module: access_lock_fsm

Interface
- REQ-001: Parameter CODE_W, default 4, width in bits of one entered digit.
- REQ-002: Parameter NUM_DIGITS, default 2, digits per code; legal range 1..8.
- REQ-003: Parameter CODE, default 8'h93, stored code packed NUM_DIGITS*CODE_W bits; first digit entered is the most significant field.
- REQ-004: Parameter MAX_TRIES, default 3, consecutive failed codes that trigger lockout; legal range 1..15.
- REQ-005: Parameter OPEN_CYCLES, default 8, clock cycles the door stays open; legal value 1 or more.
- REQ-006: Parameter LOCKOUT_CYCLES, default 16, clock cycles of lockout; legal value 1 or more.
- REQ-007: Parameter ENTRY_TIMEOUT, default 10, idle cycles allowed between digits before an entry aborts; legal value 1 or more.
- REQ-008: clk, input, 1, single clock; all state changes on rising edge.
- REQ-009: rst, input, 1, asynchronous active-high reset.
- REQ-010: validate_code, input, 1, digit strobe; access_code is sampled on each rising edge where it is 1.
- REQ-011: access_code, input, CODE_W, current digit.
- REQ-012: open_access_door, output, 1, door release.
- REQ-013: state_out, output, 2, current state encoding.
- REQ-014: fail_count, output, $clog2(MAX_TRIES+1), consecutive failed codes.
- REQ-015: entry_error, output, 1, one-cycle pulse on a wrong complete code.

Function
- REQ-016: The FSM shall have four states: IDLE=2'b00, ENTRY=2'b01, OPEN=2'b10, LOCKOUT=2'b11; state_out shall equal the state register.
- REQ-017: Outputs shall be Moore-decoded from registers only, with no combinational path from any input to any output.
- REQ-018: In IDLE or ENTRY, each sampled digit shall be compared with CODE field digit_idx; any mismatch shall set a sticky mismatch flag for the current entry.
- REQ-019: A non-final digit shall increment digit_idx and move the FSM to ENTRY.
- REQ-020: The final digit (digit_idx==NUM_DIGITS-1) shall be evaluated including its own comparison result.
- REQ-021: Correct final digit, whole code correct -> OPEN; fail_count cleared.
- REQ-022: Wrong code -> entry_error high for exactly one cycle; fail_count incremented.
- REQ-023: After a wrong code, if the new fail_count equals MAX_TRIES -> LOCKOUT, otherwise -> IDLE.
- REQ-024: digit_idx and the mismatch flag shall clear on every exit from ENTRY, and on any evaluation with NUM_DIGITS=1.
- REQ-025: With NUM_DIGITS=1, a single strobe from IDLE shall evaluate directly and shall not pass through ENTRY.
- REQ-026: In ENTRY, ENTRY_TIMEOUT consecutive cycles without validate_code -> IDLE; this abort shall not increment fail_count and shall not pulse entry_error.
- REQ-027: The ENTRY timeout counter shall reload on every strobe.
- REQ-028: open_access_door shall be 1 iff state is OPEN.
- REQ-029: open_access_door shall rise after the edge that samples the correct final digit and shall stay high for exactly OPEN_CYCLES cycles; the FSM then returns to IDLE.
- REQ-030: LOCKOUT shall last exactly LOCKOUT_CYCLES cycles, then -> IDLE with fail_count cleared.
- REQ-031: In OPEN and LOCKOUT, validate_code shall be ignored; no digit is stored and no counter changes.
- REQ-032: A strobe held high for several cycles shall be treated as one digit per cycle.
- REQ-033: fail_count shall saturate at MAX_TRIES and never wrap.
- REQ-034: Timer widths shall be sized by $clog2 of the largest cycle parameter plus 1, so terminal counts never overflow.

Reset
- REQ-035: Asserting rst at any time, including mid-entry, OPEN or LOCKOUT, shall immediately force IDLE, digit_idx=0, mismatch flag=0, timers=0, fail_count=0, open_access_door=0, entry_error=0 and state_out=2'b00.
- REQ-036: The first strobe shall be sampled at the first rising edge after rst deasserts.

Verification (default parameters)
- REQ-037: Reset mid-OPEN: enter 9,3 to open the door, assert rst 3 cycles later -> open_access_door=0 and state_out=00 immediately, without waiting for a clock edge.
- REQ-038: Correct code: strobe 9 then 3 on consecutive edges -> state_out 01 then 10; open_access_door=1 for exactly 8 cycles, then state_out=00 and fail_count=0.
- REQ-039: Wrong code: strobe 0 then 0 -> entry_error pulses once, fail_count=1, state_out=00.
- REQ-040: Lockout: three wrong codes (0,0 / 9,0 / 0,3) -> state_out=11 and fail_count=3; a correct code 9,3 entered during lockout is ignored; after 16 cycles state_out=00 and fail_count=0.
- REQ-041: Timeout: strobe 9, then 10 idle cycles -> state_out=00, fail_count unchanged, no entry_error; next entry 9,3 opens the door.
- REQ-042: Recovery: two wrong codes then 9,3 -> door opens and fail_count clears to 0.
